// File: rtl/iter_seq_controller_pkg.sv
// ----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared definitions for the iterative-datapath sequencer:
//   - state_t      : 2-bit FSM state encoding (IDLE, ARMED, RUN, DONE)
//   - MODE_HALF    : half-length operation (square root)
//   - MODE_FULL    : full-length operation (divide)
//   - seq_limit()  : number of iterations for a given width/extra/mode
// ----------------------------------------------------------------------------
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_RUN   = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic MODE_HALF = 1'b0;
    localparam logic MODE_FULL = 1'b1;

    // Square root needs one iteration per result bit (half the operand width);
    // division needs one per operand bit. EXTRA covers rounding/normalise steps.
    function automatic int seq_limit(input int nbitsin, input int extra, input logic mode);
        return (mode == MODE_FULL) ? (nbitsin + extra) : (nbitsin / 2 + extra);
    endfunction

endpackage

// File: rtl/iter_seq_controller_if.sv
// ----------------------------------------------------------------------------
// iter_seq_controller_if
// Command/status bundle between the top-level command interface (master)
// and the sequencer (slave).
//   run     : operation request, operands held while high   (master -> slave)
//   abort   : synchronous cancel                             (master -> slave)
//   mode    : 0 = half-length, 1 = full-length               (master -> slave)
//   busy    : operation in progress                          (slave -> master)
//   start   : one-cycle operand-load pulse                   (slave -> master)
//   step    : per-iteration datapath enable                  (slave -> master)
//   stop    : one-cycle result-valid pulse                   (slave -> master)
//   aborted : one-cycle cancel acknowledge                   (slave -> master)
//   iter    : current iteration index, 0 when idle           (slave -> master)
// ----------------------------------------------------------------------------
interface iter_seq_controller_if #(
    parameter int NBITSIN = 16,
    parameter int EXTRA   = 4
);
    localparam int CNTW = $clog2(NBITSIN + EXTRA + 1);

    logic            run;
    logic            abort;
    logic            mode;
    logic            busy;
    logic            start;
    logic            step;
    logic            stop;
    logic            aborted;
    logic [CNTW-1:0] iter;

    modport master (
        output run, abort, mode,
        input  busy, start, step, stop, aborted, iter
    );

    modport slave (
        input  run, abort, mode,
        output busy, start, step, stop, aborted, iter
    );

endinterface

// File: rtl/iter_seq_controller_counter.sv
// ----------------------------------------------------------------------------
// iter_counter
// CNTW-bit iteration counter with clear, enable and terminal-count compare.
//   clock    : master clock, rising edge
//   reset    : synchronous, active-high
//   i_clear  : force count to 0 (wins over enable)
//   i_enable : increment count
//   i_limit  : terminal count value
//   o_count  : registered count
//   o_tc     : count == limit
// ----------------------------------------------------------------------------
module iter_counter #(
    parameter int CNTW = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_enable,
    input  logic [CNTW-1:0] i_limit,
    output logic [CNTW-1:0] o_count,
    output logic            o_tc
);

    logic [CNTW-1:0] r_count;

    // NOTE: reset is sampled on the clock edge like any other input, so it is
    // tested inside the clocked block rather than in the sensitivity list;
    // all state updates use <= so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNTW'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_limit);

endmodule

// File: rtl/iter_seq_controller.sv
// ----------------------------------------------------------------------------
// iter_seq_controller
// Run/busy/start/stop sequencer for the iterative arithmetic datapaths.
// A rising edge on run (sampled in IDLE) is accepted: start pulses, the
// controller waits for run to fall, then asserts step for exactly `limit`
// cycles and finishes with a one-cycle stop pulse. abort cancels in ARMED or
// RUN with a one-cycle aborted pulse. All outputs are registered.
//   clock : master clock, rising edge
//   reset : synchronous, active-high, highest priority
//   bus   : iter_seq_controller_if.slave (run/abort/mode in, status out)
// ----------------------------------------------------------------------------
module iter_seq_controller
    import seq_ctrl_pkg::*;
#(
    parameter  int NBITSIN = 16,
    parameter  int EXTRA   = 4,
    localparam int CNTW    = $clog2(NBITSIN + EXTRA + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    iter_seq_controller_if.slave bus
);

    state_t          r_state;
    logic            r_run_q;
    logic            r_mode;
    logic            r_busy;
    logic            r_start;
    logic            r_step;
    logic            r_stop;
    logic            r_aborted;

    state_t          w_state_nxt;
    logic            w_mode_nxt;
    logic            w_busy_nxt;
    logic            w_start_nxt;
    logic            w_step_nxt;
    logic            w_stop_nxt;
    logic            w_aborted_nxt;
    logic            w_cnt_clear;
    logic            w_cnt_en;
    logic            w_request;
    logic            w_tc;
    logic [CNTW-1:0] w_iter;
    logic [CNTW-1:0] w_limit;

    // Edge detect: a held-high run never re-triggers after completion.
    assign w_request = bus.run && !r_run_q;
    assign w_limit   = CNTW'(seq_limit(NBITSIN, EXTRA, r_mode));

    iter_counter #(
        .CNTW (CNTW)
    ) u_iter_counter (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .i_limit  (w_limit),
        .o_count  (w_iter),
        .o_tc     (w_tc)
    );

    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_busy_nxt    = r_busy;
        w_start_nxt   = 1'b0;
        w_step_nxt    = 1'b0;
        w_stop_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_cnt_clear   = 1'b0;
        w_cnt_en      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // abort is deliberately not looked at here: a coincident
                // request is accepted.
                w_busy_nxt = 1'b0;
                if (w_request) begin
                    w_state_nxt = S_ARMED;
                    w_busy_nxt  = 1'b1;
                    w_start_nxt = 1'b1;
                    w_mode_nxt  = bus.mode;
                    w_cnt_clear = 1'b1;
                end
            end

            S_ARMED: begin
                if (bus.abort) begin
                    w_state_nxt   = S_IDLE;
                    w_busy_nxt    = 1'b0;
                    w_aborted_nxt = 1'b1;
                    w_cnt_clear   = 1'b1;
                end else if (!bus.run) begin
                    w_state_nxt = S_RUN;
                    w_step_nxt  = 1'b1;
                    w_cnt_en    = 1'b1;
                end
            end

            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt   = S_IDLE;
                    w_busy_nxt    = 1'b0;
                    w_aborted_nxt = 1'b1;
                    w_cnt_clear   = 1'b1;
                end else if (!w_tc) begin
                    w_step_nxt = 1'b1;
                    w_cnt_en   = 1'b1;
                end else begin
                    // iter holds at limit through DONE.
                    w_state_nxt = S_DONE;
                    w_stop_nxt  = 1'b1;
                end
            end

            S_DONE: begin
                // stop has already been issued, so abort no longer applies.
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_clear = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_mode_nxt  = MODE_HALF;
                w_cnt_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_run_q   <= 1'b0;
            r_mode    <= MODE_HALF;
            r_busy    <= 1'b0;
            r_start   <= 1'b0;
            r_step    <= 1'b0;
            r_stop    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_q   <= bus.run;
            r_mode    <= w_mode_nxt;
            r_busy    <= w_busy_nxt;
            r_start   <= w_start_nxt;
            r_step    <= w_step_nxt;
            r_stop    <= w_stop_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.start   = r_start;
    assign bus.step    = r_step;
    assign bus.stop    = r_stop;
    assign bus.aborted = r_aborted;
    assign bus.iter    = w_iter;

endmodule

// File: tb/tb_iter_seq_controller.sv
// ----------------------------------------------------------------------------
// tb_iter_seq_controller
// Directed testbench for iter_seq_controller (NBITSIN=16, EXTRA=4).
// Observed vector per cycle: {busy, start, step, stop, aborted, iter}.
// Expected values are hand-derived: half limit = 16/2+4 = 12, full = 16+4 = 20.
// ----------------------------------------------------------------------------
module tb_iter_seq_controller;

    localparam int NB     = 16;
    localparam int EX     = 4;
    localparam int CNTW   = $clog2(NB + EX + 1);
    localparam int L_HALF = 12;
    localparam int L_FULL = 20;
    localparam int VW     = 5 + CNTW;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    iter_seq_controller_if #(.NBITSIN(NB), .EXTRA(EX)) bus ();

    iter_seq_controller #(
        .NBITSIN (NB),
        .EXTRA   (EX)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [VW-1:0] w_obs;
    assign w_obs = {bus.busy, bus.start, bus.step, bus.stop, bus.aborted, bus.iter};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; inputs changed and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full operation from IDLE with run low (run_q=0). hold = cycles run stays
    // high (>=1); toggle flips mode during RUN; rerun_at raises run again at
    // that iteration (0 = never); abort_done pulses abort while in DONE.
    task automatic do_op(input logic m, input int hold, input int lim, input bit toggle,
                         input int rerun_at, input bit abort_done, input string tag);
        logic [VW-1:0] exp;
        bus.mode = m;
        bus.run  = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CNTW'(0)};
        n_checks++;
        if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL %s accept: got %b want %b", tag, w_obs, exp);
        end
        for (int i = 1; i < hold; i++) begin
            tick();
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CNTW'(0)};
            n_checks++;
            if (w_obs !== exp) begin
                n_errors++;
                $display("FAIL %s armed%0d: got %b want %b", tag, i, w_obs, exp);
            end
        end
        bus.run = 1'b0;
        for (int k = 1; k <= lim; k++) begin
            tick();
            exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CNTW'(k)};
            n_checks++;
            if (w_obs !== exp) begin
                n_errors++;
                $display("FAIL %s step%0d: got %b want %b", tag, k, w_obs, exp);
            end
            if (toggle && k == 3) bus.mode = ~bus.mode;
            if (k == rerun_at) bus.run = 1'b1;
        end
        tick();
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CNTW'(lim)};
        n_checks++;
        if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL %s stop: got %b want %b", tag, w_obs, exp);
        end
        bus.abort = abort_done;
        tick();
        bus.abort = 1'b0;
        exp = '0;
        n_checks++;
        if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL %s idle: got %b want %b", tag, w_obs, exp);
        end
    endtask

    task automatic test_reset();
        bus.run   = 1'b0;
        bus.abort = 1'b0;
        bus.mode  = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        n_checks++;
        if (w_obs !== '0) begin
            n_errors++;
            $display("FAIL reset_held: got %b want 0", w_obs);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (w_obs !== '0) begin
            n_errors++;
            $display("FAIL reset_released: got %b want 0", w_obs);
        end
    endtask

    task automatic test_half();
        do_op(1'b0, 3, L_HALF, 1'b0, 0, 1'b0, "half");
    endtask

    task automatic test_full_toggle();
        do_op(1'b1, 1, L_FULL, 1'b1, 0, 1'b0, "full_toggle");
    endtask

    task automatic test_run_held();
        // run rises during RUN and stays high past completion.
        do_op(1'b0, 1, L_HALF, 1'b0, 4, 1'b0, "held");
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (w_obs !== '0) begin
                n_errors++;
                $display("FAIL held_no_retrigger%0d: got %b want 0", i, w_obs);
            end
        end
        bus.run = 1'b0;
        tick();
        do_op(1'b0, 3, L_HALF, 1'b0, 0, 1'b0, "rerise");
    endtask

    task automatic test_abort();
        logic [VW-1:0] exp;
        // Abort in RUN at iter=5.
        bus.mode = 1'b0;
        bus.run  = 1'b1;
        tick();
        bus.run = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CNTW'(5)};
        n_checks++;
        if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL abort_run_pre: got %b want %b", w_obs, exp);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CNTW'(0)};
        n_checks++;
        if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL abort_run: got %b want %b", w_obs, exp);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (w_obs !== '0) begin
                n_errors++;
                $display("FAIL abort_run_after%0d: got %b want 0", i, w_obs);
            end
        end
        // Abort in ARMED, run still high.
        bus.run = 1'b1;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.run   = 1'b0;
        n_checks++;
        if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL abort_armed: got %b want %b", w_obs, exp);
        end
        tick();
        n_checks++;
        if (w_obs !== '0) begin
            n_errors++;
            $display("FAIL abort_armed_after: got %b want 0", w_obs);
        end
        // Abort alone in IDLE, then abort coincident with a request.
        bus.abort = 1'b1;
        tick();
        n_checks++;
        if (w_obs !== '0) begin
            n_errors++;
            $display("FAIL abort_idle: got %b want 0", w_obs);
        end
        do_op(1'b0, 2, L_HALF, 1'b0, 0, 1'b0, "abort_with_req");
        // Abort in DONE is ignored.
        do_op(1'b1, 1, L_FULL, 1'b0, 0, 1'b1, "abort_done");
    endtask

    task automatic test_reset_in_run();
        bus.mode = 1'b0;
        bus.run  = 1'b1;
        tick();
        bus.run = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        n_checks++;
        if (bus.iter !== CNTW'(7)) begin
            n_errors++;
            $display("FAIL rst_run_pre iter: got %0d want 7", bus.iter);
        end
        reset     = 1'b1;
        bus.abort = 1'b1;
        tick();
        n_checks++;
        if (w_obs !== '0) begin
            n_errors++;
            $display("FAIL rst_run: got %b want 0", w_obs);
        end
        reset     = 1'b0;
        bus.abort = 1'b0;
        tick();
        n_checks++;
        if (w_obs !== '0) begin
            n_errors++;
            $display("FAIL rst_run_after: got %b want 0", w_obs);
        end
        do_op(1'b0, 1, L_HALF, 1'b0, 0, 1'b0, "post_reset");
    endtask

    task automatic test_back_to_back();
        // do_op ends on the cycle busy falls; the next do_op raises run there.
        do_op(1'b0, 1, L_HALF, 1'b0, 0, 1'b0, "b2b_first");
        do_op(1'b1, 2, L_FULL, 1'b0, 0, 1'b0, "b2b_second");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_half();
        test_full_toggle();
        test_run_held();
        test_abort();
        test_reset_in_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
